iq_comp_ctrl: RTL and testbench
===============================

# iq_comp_ctrl

Calibration sequencer for the IQ compensation datapath. It drives the compensator's `op_mode`, `freeze_iqcomp` and `Wr_in`/`Wj_in` inputs, and watches its `Wr`/`Wj` outputs. On request it runs an internal-W training pass, detects convergence (or times out), and latches the converged coefficients. It then switches the compensator to external-W mode using the latched values. It sits between the start-signal FSM/MCU and the compensator, and exposes status for the MCU to read or restore coefficients.

## Interface
- `WARMUP`, default 256: cycles in internal-W mode before convergence checking begins (≥1).
- `SETTLE_LEN`, default 64: consecutive stable cycles required to declare convergence (≥1).
- `TOL`, default 4: maximum |ΔW| per cycle, in both Wr and Wj, that counts as stable (unsigned, ≤4095).
- `TIMEOUT`, default 16384: maximum cycles in WARMUP+TRACK before forced latch (must exceed `WARMUP`; counter width = clog2(TIMEOUT+1)).
- `clk`  in  1  sole clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `enable`  in  1  low forces IDLE/bypass.
- `start`  in  1  single-cycle request to begin training.
- `abort`  in  1  cancels training in progress.
- `w_load`  in  1  single-cycle request to load externally supplied coefficients.
- `w_load_r`, `w_load_j`  in  13 signed  coefficients written on `w_load`.
- `Wr`, `Wj`  in  13 signed  current coefficients reported by the compensator.
- `op_mode`  out  2  to the compensator: 00 bypass, 01 internal W, 10 external W.
- `freeze_iqcomp`  out  1  to the compensator.
- `Wr_ext`, `Wj_ext`  out  13 signed  stored coefficients, driven to the compensator's `Wr_in`/`Wj_in`.
- `busy`  out  1  high in WARMUP, TRACK and LATCH.
- `done`  out  1  high while in APPLY.
- `timed_out`  out  1  sticky flag: the last training ended by timeout.

## Operation
- All outputs are registered. Reset values: `op_mode`=00, `freeze_iqcomp`=1, `Wr_ext`=`Wj_ext`=0, `busy`=0, `done`=0, `timed_out`=0, state IDLE, all counters 0.
- Output encoding by state:
  - IDLE: op_mode=00, freeze=1.
  - WARMUP and TRACK: op_mode=01, freeze=0, busy=1.
  - LATCH: op_mode=01, freeze=1, busy=1.
  - APPLY: op_mode=10, freeze=1, done=1.
- IDLE → WARMUP on `start`. Clear `timed_out`, `cyc_cnt` and `stable_cnt`.
- IDLE → APPLY on `w_load`. Write `Wr_ext`/`Wj_ext` from `w_load_r`/`w_load_j` and clear `timed_out`.
- WARMUP → TRACK when `cyc_cnt` reaches WARMUP-1.
- Stability check in TRACK:
  - A 13-bit register `Wr_prev`/`Wj_prev` samples `Wr`/`Wj` every cycle.
  - dr = Wr − Wr_prev and dj = Wj − Wj_prev, computed at 14-bit signed width (no overflow).
  - A cycle is stable when |dr| ≤ TOL and |dj| ≤ TOL.
  - A stable cycle increments `stable_cnt`; an unstable cycle clears it.
- TRACK → LATCH on a stable cycle with `stable_cnt`=SETTLE_LEN-1.
- WARMUP/TRACK → LATCH when `cyc_cnt` reaches TIMEOUT-1. This sets `timed_out`. Timeout takes precedence over settling in the same cycle, so `timed_out`=1.
- `cyc_cnt` increments every cycle in WARMUP and TRACK.
- LATCH lasts exactly one cycle. At its exit edge, capture `Wr`/`Wj` into `Wr_ext`/`Wj_ext`, then go to APPLY.
- APPLY → WARMUP on `start` (retrain) and → APPLY on `w_load` (reload). Both behave as from IDLE.
- Precedence, highest first: RESET, then `enable`=0, then `abort`, then `start`, then `w_load`.
  - `enable`=0 in any state → IDLE next cycle. `Wr_ext`/`Wj_ext` are kept.
  - `abort` in WARMUP/TRACK → IDLE. `Wr_ext`/`Wj_ext` are unchanged.
  - `abort` in LATCH is ignored; the latch completes.
  - `start` and `w_load` are ignored in WARMUP, TRACK and LATCH.
  - `start` and `w_load` in the same cycle: `start` wins.
  - `abort` outside a training state has no effect.
- RESET mid-training: immediate return to reset values; stored coefficients are lost.

## Timing
- `start` sampled at edge t0 → WARMUP from t0. op_mode=01 and freeze=0 are visible after t0.
- WARMUP occupies cycles t0 … t0+WARMUP-1. TRACK is entered at t0+WARMUP.
- With W constant throughout, LATCH is entered at t0+WARMUP+SETTLE_LEN. APPLY is entered at t0+WARMUP+SETTLE_LEN+1 (`done`=1, op_mode=10).
- Timeout case: LATCH at t0+TIMEOUT, APPLY at t0+TIMEOUT+1.
- Why the capture is safe: freeze rises on entry to LATCH, so the compensator makes its last update at that edge and holds W from the next edge. Capturing at the LATCH exit edge therefore gets the final, stable W.
- The compensator reflects `Wr_ext` on its `Wr` output one cycle after APPLY entry.
- `w_load` at edge t → `Wr_ext`/`Wj_ext`, op_mode=10 and `done` all valid after t (1-cycle latency).
- `enable` falling at edge t → op_mode=00 and freeze=1 after t.

## Test plan
- Reset: assert RESET for 2 cycles → op_mode=00, freeze=1, Wr_ext=Wj_ext=0, busy=done=timed_out=0.
- Settle (WARMUP=4, SETTLE_LEN=8, TOL=2, TIMEOUT=100), Wr=37, Wj=−12 held constant, `start` at t0 → busy t0…t0+12; done=1, op_mode=10 and Wr_ext=37/Wj_ext=−12 at t0+13; timed_out=0.
- Jitter: Wr steps by +5 at TRACK cycle 5, then constant → stable_cnt restarts; LATCH is delayed by 6 cycles versus the settle case.
- Timeout: Wr toggles between 0 and 10 every cycle → LATCH at t0+100, done at t0+101 with timed_out=1 and the captured Wr equal to the last value sampled.
- Abort: `abort` at t0+6 after a prior `w_load` of (100, −50) → IDLE at t0+7, op_mode=00, Wr_ext/Wj_ext still 100/−50. A same-cycle `start`+`abort` in TRACK → IDLE.
- Load/enable: `w_load` (−4096, 4095) in IDLE → done and op_mode=10 next cycle with exact values. Then `enable`=0 → IDLE next cycle with values retained. `start`+`w_load` together → WARMUP.

Source files
------------

// File: rtl/iq_comp_ctrl.sv
// iq_comp_ctrl: calibration sequencer for the IQ compensator.
//   Runs an internal-W training pass, waits for Wr/Wj to settle (or time out),
//   latches the converged coefficients and then drives the compensator in
//   external-W mode with them.
// Ports:
//   clk, RESET            clock, synchronous active-high reset
//   enable                low forces IDLE/bypass
//   start, abort          begin / cancel a training pass
//   w_load, w_load_r/j    load externally supplied coefficients
//   Wr, Wj                coefficients reported by the compensator
//   op_mode               00 bypass, 01 internal W, 10 external W
//   freeze_iqcomp         freezes the compensator's adaptation
//   Wr_ext, Wj_ext        stored coefficients to the compensator's Wr_in/Wj_in
//   busy, done, timed_out status for the MCU
module iq_comp_ctrl #(
    parameter int WARMUP     = 256,
    parameter int SETTLE_LEN = 64,
    parameter int TOL        = 4,
    parameter int TIMEOUT    = 16384
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               enable,
    input  logic               start,
    input  logic               abort,
    input  logic               w_load,
    input  logic signed [12:0] w_load_r,
    input  logic signed [12:0] w_load_j,
    input  logic signed [12:0] Wr,
    input  logic signed [12:0] Wj,
    output logic [1:0]         op_mode,
    output logic               freeze_iqcomp,
    output logic signed [12:0] Wr_ext,
    output logic signed [12:0] Wj_ext,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_WARM, S_TRACK, S_LATCH, S_APPLY} state_t;

    state_t             state, nxt;
    logic [CW-1:0]      cyc_cnt;
    logic [SW-1:0]      stable_cnt;
    logic signed [12:0] Wr_prev, Wj_prev;
    logic signed [13:0] dr, dj;
    logic [13:0]        adr, adj;
    logic               stable, tmo, settled, idle_like, go_train, go_load, training;

    // 14-bit differences cannot overflow, so the magnitude always fits too
    assign dr       = {Wr[12], Wr} - {Wr_prev[12], Wr_prev};
    assign dj       = {Wj[12], Wj} - {Wj_prev[12], Wj_prev};
    assign adr      = dr[13] ? 14'(-dr) : 14'(dr);
    assign adj      = dj[13] ? 14'(-dj) : 14'(dj);
    assign stable   = adr <= 14'(TOL) && adj <= 14'(TOL);
    assign tmo      = cyc_cnt == CW'(TIMEOUT - 1);
    assign settled  = stable && stable_cnt == SW'(SETTLE_LEN - 1);
    assign training = state == S_WARM || state == S_TRACK;

    // start/w_load are only honoured from IDLE or APPLY; start wins over w_load
    assign idle_like = enable && (state == S_IDLE || state == S_APPLY);
    assign go_train  = idle_like && start;
    assign go_load   = idle_like && !start && w_load;

    always_comb begin
        nxt = state;
        if (!enable)
            nxt = S_IDLE;
        else
            case (state)
                S_IDLE, S_APPLY: nxt = start ? S_WARM : w_load ? S_APPLY : state;
                S_WARM:  nxt = abort ? S_IDLE : tmo ? S_LATCH
                             : cyc_cnt == CW'(WARMUP - 1) ? S_TRACK : S_WARM;
                S_TRACK: nxt = abort ? S_IDLE : (tmo || settled) ? S_LATCH : S_TRACK;
                S_LATCH: nxt = S_APPLY;
                default: nxt = S_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state         <= S_IDLE;
            op_mode       <= 2'b00;
            freeze_iqcomp <= 1'b1;
            Wr_ext        <= '0;
            Wj_ext        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timed_out     <= 1'b0;
            cyc_cnt       <= '0;
            stable_cnt    <= '0;
            Wr_prev       <= '0;
            Wj_prev       <= '0;
        end else begin
            state         <= nxt;
            op_mode       <= nxt == S_APPLY ? 2'b10 : nxt == S_IDLE ? 2'b00 : 2'b01;
            freeze_iqcomp <= !(nxt == S_WARM || nxt == S_TRACK);
            busy          <= nxt == S_WARM || nxt == S_TRACK || nxt == S_LATCH;
            done          <= nxt == S_APPLY;
            Wr_prev       <= Wr;
            Wj_prev       <= Wj;
            cyc_cnt       <= go_train ? '0 : training ? cyc_cnt + 1'b1 : cyc_cnt;
            stable_cnt    <= go_train ? '0 : state == S_TRACK ? (stable ? stable_cnt + 1'b1 : '0) : stable_cnt;
            // only WARM/TRACK can lead to LATCH, and there a timeout outranks settling
            timed_out     <= (go_train || go_load) ? 1'b0 : (nxt == S_LATCH && tmo) ? 1'b1 : timed_out;
            // freeze has held W since LATCH entry, so the exit edge sees the final value
            Wr_ext        <= go_load ? w_load_r : (state == S_LATCH && nxt == S_APPLY) ? Wr : Wr_ext;
            Wj_ext        <= go_load ? w_load_j : (state == S_LATCH && nxt == S_APPLY) ? Wj : Wj_ext;
        end
    end
endmodule

// File: tb/tb_iq_comp_ctrl.sv
// tb_iq_comp_ctrl: scoreboard bench for iq_comp_ctrl with directed vectors.
module tb_iq_comp_ctrl;
    localparam int WU = 4, SL = 8, TL = 2, TO = 100;

    logic clk = 0, RESET = 1, enable = 1, start = 0, abort = 0, w_load = 0;
    logic signed [12:0] w_load_r = '0, w_load_j = '0, Wr = '0, Wj = '0;
    logic [1:0] op_mode;
    logic freeze_iqcomp, busy, done, timed_out;
    logic signed [12:0] Wr_ext, Wj_ext;

    iq_comp_ctrl #(.WARMUP(WU), .SETTLE_LEN(SL), .TOL(TL), .TIMEOUT(TO)) dut (
        .clk(clk), .RESET(RESET), .enable(enable), .start(start), .abort(abort),
        .w_load(w_load), .w_load_r(w_load_r), .w_load_j(w_load_j), .Wr(Wr), .Wj(Wj),
        .op_mode(op_mode), .freeze_iqcomp(freeze_iqcomp), .Wr_ext(Wr_ext), .Wj_ext(Wj_ext),
        .busy(busy), .done(done), .timed_out(timed_out)
    );

    // expected output vector: {op_mode, freeze, busy, done, timed_out, Wr_ext, Wj_ext}
    typedef struct {
        int          at;
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [31:0] act;
    int edge_n = 0, n_checks = 0, n_pass = 0;
    logic signed [12:0] cur_r = '0, cur_j = '0;
    logic cur_to = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // monitor: compares every expectation due at this edge, half a cycle after it
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_n) begin
            e = q.pop_front();
            act = {op_mode, freeze_iqcomp, busy, done, timed_out, Wr_ext, Wj_ext};
            n_checks++;
            if (e.at == edge_n && act === e.v) n_pass++;
            else $display("FAIL %s edge %0d: got %h want %h%s", e.tag, e.at, act, e.v,
                          e.at != edge_n ? " (missed)" : "");
        end
    end

    task automatic push(input int at, input string tag, input logic [1:0] op,
                        input logic frz, input logic b, input logic d);
        q.push_back('{at, tag, {op, frz, b, d, cur_to, cur_r, cur_j}});
    endtask
    task automatic e_idle(input int at, input string tag);  push(at, tag, 2'b00, 1'b1, 1'b0, 1'b0); endtask
    task automatic e_apply(input int at, input string tag); push(at, tag, 2'b10, 1'b1, 1'b0, 1'b1); endtask
    task automatic e_busy(input int at, input string tag, input logic frz);
        push(at, tag, 2'b01, frz, 1'b1, 1'b0);
    endtask
    task automatic step(input int n); repeat (n) @(negedge clk); endtask
    task automatic step_to(input int n); while (edge_n < n) @(negedge clk); endtask

    initial begin
        int t0;
        Wr = 13'sd37;
        Wj = -13'sd12;
        step(2);
        e_idle(edge_n + 1, "reset");
        e_idle(edge_n + 2, "reset_hold");
        step(1);
        RESET = 0;
        step(1);

        // settle with constant W; abort during LATCH must be ignored
        start = 1;
        t0 = edge_n + 1;
        e_busy(t0, "warm_entry", 1'b0);
        e_busy(t0 + WU, "track_entry", 1'b0);
        e_busy(t0 + WU + SL - 1, "pre_latch", 1'b0);
        e_busy(t0 + WU + SL, "settle_latch", 1'b1);
        step(1);
        start = 0;
        step_to(t0 + WU + SL);
        abort = 1;
        cur_r = 13'sd37;
        cur_j = -13'sd12;
        e_apply(t0 + WU + SL + 1, "settle_apply");
        step(1);
        abort = 0;

        // jitter: one unstable step in TRACK cycle 5 delays LATCH by 6
        start = 1;
        t0 = edge_n + 1;
        e_busy(t0, "jit_warm", 1'b0);
        e_busy(t0 + WU + SL, "jit_no_latch", 1'b0);
        e_busy(t0 + WU + SL + 5, "jit_pre", 1'b0);
        e_busy(t0 + WU + SL + 6, "jit_latch", 1'b1);
        step(1);
        w_load = 1;
        w_load_r = 13'sd999;
        w_load_j = 13'sd9;
        step(1);
        start = 0;
        w_load = 0;
        step_to(t0 + WU + 5);
        Wr = 13'sd42;
        step_to(t0 + WU + SL + 6);
        cur_r = 13'sd42;
        e_apply(t0 + WU + SL + 7, "jit_apply");
        step(1);

        // timeout: W toggles every cycle and never settles
        start = 1;
        t0 = edge_n + 1;
        e_busy(t0, "to_warm", 1'b0);
        e_busy(t0 + TO - 1, "to_pre", 1'b0);
        cur_to = 1'b1;
        e_busy(t0 + TO, "to_latch", 1'b1);
        cur_r = ((t0 + TO) % 2 == 1) ? 13'sd10 : 13'sd0;
        e_apply(t0 + TO + 1, "to_apply");
        step(1);
        start = 0;
        while (edge_n <= t0 + TO) begin
            Wr = edge_n[0] ? 13'sd10 : 13'sd0;
            step(1);
        end

        // load then abort in TRACK
        w_load = 1;
        w_load_r = 13'sd100;
        w_load_j = -13'sd50;
        cur_r = 13'sd100;
        cur_j = -13'sd50;
        cur_to = 1'b0;
        e_apply(edge_n + 1, "load_100");
        step(1);
        w_load = 0;
        start = 1;
        t0 = edge_n + 1;
        e_busy(t0, "ab_warm", 1'b0);
        e_busy(t0 + 6, "ab_pre", 1'b0);
        e_idle(t0 + 7, "ab_idle");
        step(1);
        start = 0;
        step_to(t0 + 6);
        abort = 1;
        step(1);
        abort = 0;

        // start + abort together in TRACK: abort wins
        start = 1;
        t0 = edge_n + 1;
        e_busy(t0 + 5, "sa_track", 1'b0);
        e_idle(t0 + 6, "sa_idle");
        step(1);
        start = 0;
        step_to(t0 + 5);
        start = 1;
        abort = 1;
        step(1);
        start = 0;
        abort = 0;

        // extreme load, abort in APPLY, enable low, start beats w_load
        w_load = 1;
        w_load_r = 13'h1000;
        w_load_j = 13'sd4095;
        cur_r = 13'h1000;
        cur_j = 13'sd4095;
        e_apply(edge_n + 1, "load_ext");
        step(1);
        w_load = 0;
        abort = 1;
        e_apply(edge_n + 1, "abort_apply");
        step(1);
        abort = 0;
        enable = 0;
        e_idle(edge_n + 1, "en_off");
        step(1);
        enable = 1;
        start = 1;
        w_load = 1;
        w_load_r = 13'sd5;
        w_load_j = 13'sd5;
        e_busy(edge_n + 1, "start_wins", 1'b0);
        step(1);
        start = 0;
        w_load = 0;
        step(1);
        enable = 0;
        e_idle(edge_n + 1, "en_off_train");
        step(1);
        enable = 1;

        // reset in the middle of training drops stored coefficients
        start = 1;
        t0 = edge_n + 1;
        step(1);
        start = 0;
        step_to(t0 + 2);
        RESET = 1;
        cur_r = '0;
        cur_j = '0;
        e_idle(t0 + 3, "reset_mid");
        step(1);
        RESET = 0;

        step(2);
        for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
